// File: rtl/mem_access_unit.sv
// Load/store unit between a core request port and a single-outstanding memory port.
// Handles lane alignment, store replication, load extension, address errors and flush.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              err_valid,
    output logic              err_store,
    output logic [ADDR_W-1:0] err_badvaddr,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int NB  = DATA_W / 8;
    localparam int OFS = $clog2(NB);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic            is_store;
    logic [1:0]      size_q;
    logic            signed_q;
    logic [OFS-1:0]  lane_q;

    logic            handshake;
    logic            misaligned;
    logic            accept;
    logic            bad_req;
    int              nbytes;
    logic [NB-1:0]   wen_next;
    logic [DATA_W-1:0] wdata_next;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_mask;
    logic              sign_bit;
    logic [DATA_W-1:0] load_data;

    assign req_ready  = (state == IDLE);
    assign handshake  = req_valid && req_ready;
    assign accept     = handshake && !misaligned;
    assign bad_req    = handshake && misaligned;
    assign resp_valid = (state == RESP) && !flush;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = (DATA_W == 32) || (|req_addr[2:0]);
        endcase
    end

    // Store lane enables and replicated write data, computed from the live request.
    always_comb begin
        wen_next   = '0;
        wdata_next = '0;
        nbytes     = 1 << req_size;
        for (int i = 0; i < NB; i++) begin
            wen_next[i] = req_we
                       && (i >= int'(req_addr[OFS-1:0]))
                       && (i < int'(req_addr[OFS-1:0]) + nbytes);
            wdata_next[8*i +: 8] = req_wdata[8*(i & (nbytes - 1)) +: 8];
        end
    end

    // Load extraction: shift the addressed lane down, mask, then optionally sign-fill.
    always_comb begin
        shifted   = mem_rdata >> {lane_q, 3'b000};
        load_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            load_mask[i] = (i < (8 << size_q));
        end
        case (size_q)
            2'd0:    sign_bit = shifted[7];
            2'd1:    sign_bit = shifted[15];
            2'd2:    sign_bit = shifted[31];
            default: sign_bit = shifted[DATA_W-1];
        endcase
        load_data = (shifted & load_mask) | ((signed_q && sign_bit) ? ~load_mask : '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                if (mem_gnt) begin
                    if (flush) state_next = is_store ? IDLE : DRAIN;
                    else       state_next = is_store ? RESP : WAIT;
                end else if (flush) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid)  state_next = flush ? IDLE : RESP;
                else if (flush)  state_next = DRAIN;
            end
            RESP: begin
                if (flush || resp_ready) state_next = IDLE;
            end
            DRAIN: begin
                if (mem_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, memory-side registers, response data and error reporting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_req      <= 1'b0;
            mem_wen      <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            is_store     <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            lane_q       <= '0;
            resp_rdata   <= '0;
            err_valid    <= 1'b0;
            err_store    <= 1'b0;
            err_badvaddr <= '0;
        end else begin
            err_valid <= bad_req;
            if (bad_req) begin
                err_store    <= req_we;
                err_badvaddr <= req_addr;
            end

            if (accept) begin
                mem_req   <= 1'b1;
                mem_addr  <= {req_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
                mem_wen   <= wen_next;
                mem_wdata <= wdata_next;
                is_store  <= req_we;
                size_q    <= req_size;
                signed_q  <= req_signed;
                lane_q    <= req_addr[OFS-1:0];
            end else if (state == ISSUE && (mem_gnt || flush)) begin
                mem_req <= 1'b0;
                mem_wen <= '0;
            end

            if (state == ISSUE && mem_gnt && is_store) begin
                resp_rdata <= '0;
            end
            if (state == WAIT && mem_rvalid && !flush) begin
                resp_rdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance for most cases and a
// 64-bit instance for the wide-lane loads and stores.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;

    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        flush, resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        err_valid, err_store;
    logic [31:0] err_badvaddr;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        req_valid_w, req_ready_w, req_we_w, req_signed_w;
    logic [1:0]  req_size_w;
    logic [31:0] req_addr_w;
    logic [63:0] req_wdata_w;
    logic        flush_w, resp_valid_w, resp_ready_w;
    logic [63:0] resp_rdata_w;
    logic        err_valid_w, err_store_w;
    logic [31:0] err_badvaddr_w;
    logic        mem_req_w, mem_gnt_w, mem_rvalid_w;
    logic [7:0]  mem_wen_w;
    logic [31:0] mem_addr_w;
    logic [63:0] mem_wdata_w, mem_rdata_w;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .err_valid(err_valid), .err_store(err_store), .err_badvaddr(err_badvaddr),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut_wide (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid_w), .req_ready(req_ready_w), .req_we(req_we_w),
        .req_size(req_size_w), .req_signed(req_signed_w), .req_addr(req_addr_w),
        .req_wdata(req_wdata_w), .flush(flush_w),
        .resp_valid(resp_valid_w), .resp_ready(resp_ready_w), .resp_rdata(resp_rdata_w),
        .err_valid(err_valid_w), .err_store(err_store_w), .err_badvaddr(err_badvaddr_w),
        .mem_req(mem_req_w), .mem_gnt(mem_gnt_w), .mem_wen(mem_wen_w),
        .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w),
        .mem_rvalid(mem_rvalid_w), .mem_rdata(mem_rdata_w)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        checkOutput("req_ready", {63'd0, req_ready}, 64'd1);
        step();
        req_valid  = 1'b0;
    endtask

    task automatic doLoad(input string tag, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] expected);
        applyStimulus(1'b0, size, sgn, addr, 32'd0);
        checkOutput({tag, ".mem_req"}, {63'd0, mem_req}, 64'd1);
        checkOutput({tag, ".mem_addr"}, {32'd0, mem_addr}, {32'd0, addr & 32'hFFFF_FFFC});
        checkOutput({tag, ".mem_wen"}, {60'd0, mem_wen}, 64'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        checkOutput({tag, ".req_drop"}, {63'd0, mem_req}, 64'd0);
        checkOutput({tag, ".early_resp"}, {63'd0, resp_valid}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        checkOutput({tag, ".resp_valid"}, {63'd0, resp_valid}, 64'd1);
        checkOutput({tag, ".rdata"}, {32'd0, resp_rdata}, {32'd0, expected});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checkOutput({tag, ".resp_done"}, {63'd0, resp_valid}, 64'd0);
    endtask

    task automatic doStore(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] exp_wen,
                           input logic [31:0] exp_wdata);
        applyStimulus(1'b1, size, 1'b0, addr, wdata);
        checkOutput({tag, ".mem_req"}, {63'd0, mem_req}, 64'd1);
        checkOutput({tag, ".mem_addr"}, {32'd0, mem_addr}, {32'd0, addr & 32'hFFFF_FFFC});
        checkOutput({tag, ".mem_wen"}, {60'd0, mem_wen}, {60'd0, exp_wen});
        checkOutput({tag, ".mem_wdata"}, {32'd0, mem_wdata}, {32'd0, exp_wdata});
        step();
        checkOutput({tag, ".req_hold"}, {63'd0, mem_req}, 64'd1);
        checkOutput({tag, ".wen_hold"}, {60'd0, mem_wen}, {60'd0, exp_wen});
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        checkOutput({tag, ".req_drop"}, {63'd0, mem_req}, 64'd0);
        checkOutput({tag, ".resp_valid"}, {63'd0, resp_valid}, 64'd1);
        checkOutput({tag, ".rdata0"}, {32'd0, resp_rdata}, 64'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checkOutput({tag, ".resp_done"}, {63'd0, resp_valid}, 64'd0);
    endtask

    task automatic doError(input string tag, input logic we, input logic [1:0] size,
                           input logic [31:0] addr);
        applyStimulus(we, size, 1'b0, addr, 32'h1234_5678);
        checkOutput({tag, ".err_valid"}, {63'd0, err_valid}, 64'd1);
        checkOutput({tag, ".err_store"}, {63'd0, err_store}, {63'd0, we});
        checkOutput({tag, ".badvaddr"}, {32'd0, err_badvaddr}, {32'd0, addr});
        checkOutput({tag, ".no_req"}, {63'd0, mem_req}, 64'd0);
        step();
        checkOutput({tag, ".err_pulse"}, {63'd0, err_valid}, 64'd0);
        checkOutput({tag, ".no_req2"}, {63'd0, mem_req}, 64'd0);
        checkOutput({tag, ".idle"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic doLoadWide(input string tag, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [63:0] rdata,
                              input logic [63:0] expected);
        req_valid_w  = 1'b1;
        req_we_w     = 1'b0;
        req_size_w   = size;
        req_signed_w = sgn;
        req_addr_w   = addr;
        checkOutput({tag, ".ready"}, {63'd0, req_ready_w}, 64'd1);
        step();
        req_valid_w  = 1'b0;
        checkOutput({tag, ".mem_addr"}, {32'd0, mem_addr_w}, {32'd0, addr & 32'hFFFF_FFF8});
        mem_gnt_w = 1'b1;
        step();
        mem_gnt_w    = 1'b0;
        mem_rvalid_w = 1'b1;
        mem_rdata_w  = rdata;
        step();
        mem_rvalid_w = 1'b0;
        mem_rdata_w  = 64'd0;
        checkOutput({tag, ".resp_valid"}, {63'd0, resp_valid_w}, 64'd1);
        checkOutput({tag, ".rdata"}, resp_rdata_w, expected);
        resp_ready_w = 1'b1;
        step();
        resp_ready_w = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        resetn = 1'b0;
        req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
        flush = 0; resp_ready = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        req_valid_w = 0; req_we_w = 0; req_size_w = 0; req_signed_w = 0; req_addr_w = 0;
        req_wdata_w = 0; flush_w = 0; resp_ready_w = 0; mem_gnt_w = 0; mem_rvalid_w = 0;
        mem_rdata_w = 0;

        #3;
        checkOutput("rst.mem_req", {63'd0, mem_req}, 64'd0);
        checkOutput("rst.mem_wen", {60'd0, mem_wen}, 64'd0);
        checkOutput("rst.resp_valid", {63'd0, resp_valid}, 64'd0);
        checkOutput("rst.err_valid", {63'd0, err_valid}, 64'd0);
        checkOutput("rst.resp_rdata", {32'd0, resp_rdata}, 64'd0);
        checkOutput("rst.badvaddr", {32'd0, err_badvaddr}, 64'd0);
        step();
        step();
        resetn = 1'b1;
        step();
        checkOutput("rst.req_ready", {63'd0, req_ready}, 64'd1);

        // Loads with all extension cases on the 32-bit datapath.
        doLoad("lb_signed", 2'd0, 1'b1, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80);
        doLoad("lbu", 2'd0, 1'b0, 32'h0000_0101, 32'h0000_F200, 32'h0000_00F2);
        doLoad("lh_signed", 2'd1, 1'b1, 32'h0000_0102, 32'h8001_5555, 32'hFFFF_8001);
        doLoad("lhu", 2'd1, 1'b0, 32'h0000_0100, 32'h1234_9876, 32'h0000_9876);
        doLoad("lw_signed", 2'd2, 1'b1, 32'h0000_0108, 32'h8765_4321, 32'h8765_4321);

        // Stores: lane enables and replication.
        doStore("sh", 2'd1, 32'h0000_0202, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
        doStore("sb", 2'd0, 32'h0000_0301, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        doStore("sw", 2'd2, 32'h0000_0304, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        // Address errors, including one coinciding with flush.
        doError("lw_mis", 1'b0, 2'd2, 32'h0000_0101);
        doError("sh_mis", 1'b1, 2'd1, 32'h0000_0203);
        doError("sd_on32", 1'b1, 2'd3, 32'h0000_0000);
        flush = 1'b1;
        doError("err_flush", 1'b0, 2'd1, 32'h0000_0011);
        flush = 1'b0;

        // Held response: resp_ready low for 4 cycles.
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            checkOutput("hold.valid", {63'd0, resp_valid}, 64'd1);
            checkOutput("hold.rdata", {32'd0, resp_rdata}, 64'h1234_5678);
            checkOutput("hold.no_accept", {63'd0, req_ready}, 64'd0);
            step();
        end
        resp_ready = 1'b1;
        checkOutput("hold.valid5", {63'd0, resp_valid}, 64'd1);
        checkOutput("hold.rdata5", {32'd0, resp_rdata}, 64'h1234_5678);
        step();
        resp_ready = 1'b0;
        checkOutput("hold.done", {63'd0, resp_valid}, 64'd0);

        // Flush in WAIT, read data returns three cycles later and is drained.
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("drain.resp0", {63'd0, resp_valid}, 64'd0);
        checkOutput("drain.busy", {63'd0, req_ready}, 64'd0);
        step();
        step();
        checkOutput("drain.resp1", {63'd0, resp_valid}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_CAFE;
        step();
        mem_rvalid = 1'b0;
        checkOutput("drain.resp2", {63'd0, resp_valid}, 64'd0);
        checkOutput("drain.idle", {63'd0, req_ready}, 64'd1);
        doLoad("after_drain", 2'd0, 1'b0, 32'h0000_0402, 32'h00AB_0000, 32'h0000_00AB);

        // Flush in ISSUE without grant abandons the request.
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("flush_issue.req", {63'd0, mem_req}, 64'd0);
        checkOutput("flush_issue.idle", {63'd0, req_ready}, 64'd1);
        checkOutput("flush_issue.resp", {63'd0, resp_valid}, 64'd0);

        // Flush on a granted store: write goes out, no response.
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_0600, 32'h0BAD_F00D);
        checkOutput("flush_st.wen", {60'd0, mem_wen}, 64'hF);
        mem_gnt = 1'b1;
        flush   = 1'b1;
        step();
        mem_gnt = 1'b0;
        flush   = 1'b0;
        checkOutput("flush_st.resp", {63'd0, resp_valid}, 64'd0);
        checkOutput("flush_st.idle", {63'd0, req_ready}, 64'd1);

        // Flush in RESP drops the pending response.
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h0000_0700, 32'h0000_0011);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("flush_resp.resp", {63'd0, resp_valid}, 64'd0);
        checkOutput("flush_resp.idle", {63'd0, req_ready}, 64'd1);

        // Reset in WAIT, then a stray read-valid in IDLE.
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0800, 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        resetn  = 1'b0;
        #1;
        checkOutput("midrst.req", {63'd0, mem_req}, 64'd0);
        checkOutput("midrst.idle", {63'd0, req_ready}, 64'd1);
        #1;
        resetn = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        checkOutput("midrst.resp", {63'd0, resp_valid}, 64'd0);
        checkOutput("midrst.rdata", {32'd0, resp_rdata}, 64'd0);

        // 64-bit datapath.
        doLoadWide("w_lhu", 2'd1, 1'b0, 32'h0000_1006, 64'hABCD_0000_0000_0000, 64'h0000_0000_0000_ABCD);
        doLoadWide("w_lw", 2'd2, 1'b1, 32'h0000_1004, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
        doLoadWide("w_ld", 2'd3, 1'b1, 32'h0000_1008, 64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF);

        req_valid_w = 1'b1;
        req_we_w    = 1'b1;
        req_size_w  = 2'd2;
        req_addr_w  = 32'h0000_2004;
        req_wdata_w = 64'h1111_2222_CAFE_F00D;
        step();
        req_valid_w = 1'b0;
        checkOutput("w_sw.wen", {56'd0, mem_wen_w}, 64'hF0);
        checkOutput("w_sw.wdata", mem_wdata_w, 64'hCAFE_F00D_CAFE_F00D);
        checkOutput("w_sw.addr", {32'd0, mem_addr_w}, 64'h2000);
        mem_gnt_w = 1'b1;
        step();
        mem_gnt_w = 1'b0;
        checkOutput("w_sw.resp", {63'd0, resp_valid_w}, 64'd1);
        resp_ready_w = 1'b1;
        step();
        resp_ready_w = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, meaning data path width in bits; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, meaning byte address width.
REQ-003 Derived constant NB = DATA_W/8, meaning byte lanes; OFS = log2(NB), meaning low address bits selecting a lane.
REQ-004 Port list, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  unit accepts request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64)
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- flush  in  1  abort the in-flight access
- resp_valid  out  1  access complete
- resp_ready  in  1  core consumes response
- resp_rdata  out  DATA_W  aligned, extended load data (0 for stores)
- err_valid  out  1  one-cycle address-error pulse
- err_store  out  1  1 = store error (AdES), 0 = load error (AdEL)
- err_badvaddr  out  ADDR_W  faulting address
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepted request
- mem_wen  out  NB  byte-lane write enables, all 0 for loads
- mem_addr  out  ADDR_W  req_addr with low OFS bits cleared
- mem_wdata  out  DATA_W  store data replicated into the addressed lanes
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  full-width read data

Function
REQ-005 States: IDLE, ISSUE, WAIT, RESP, DRAIN; one access is outstanding at most.
REQ-006 req_ready SHALL be 1 only in IDLE; a handshake is req_valid and req_ready high in the same cycle.
REQ-007 Misaligned access (address not a multiple of 2^req_size), or size 3 with DATA_W=32: the unit stays in IDLE and pulses err_valid, err_store=req_we and err_badvaddr=req_addr in the next cycle; no mem_req is issued.
REQ-008 Aligned handshake: IDLE->ISSUE; in the following cycle registered mem_req=1 with mem_addr, mem_wen and mem_wdata held stable until mem_gnt.
REQ-009 Store lanes: mem_wen has 2^size consecutive ones starting at lane addr[OFS-1:0]; mem_wdata replicates the low 8*2^size bits of req_wdata across the word.
REQ-010 ISSUE with mem_gnt: a store goes to RESP; a load goes to WAIT; mem_req drops in the next cycle.
REQ-011 WAIT with mem_rvalid: the selected lane is captured as resp_rdata, zero- or sign-extended per req_signed, and the state goes to RESP; size 2 on DATA_W=32, and size 3, ignore req_signed.
REQ-012 RESP: resp_valid=1 and resp_rdata is held until resp_ready=1, then the state goes to IDLE; a new request is accepted no earlier than the cycle after.
REQ-013 Best-case latency: a load with mem_gnt and mem_rvalid asserted immediately has 3 cycles from handshake to resp_valid; a store has 2 cycles.
REQ-014 flush in ISSUE without mem_gnt -> IDLE, with no response.
REQ-015 flush in ISSUE with mem_gnt on a load, or flush in WAIT without mem_rvalid -> DRAIN; DRAIN discards the next mem_rvalid, then goes to IDLE.
REQ-016 flush in WAIT with mem_rvalid, or flush in RESP -> IDLE, with no resp_valid.
REQ-017 flush on a granted store: the write is committed and the response is suppressed.
REQ-018 flush in IDLE is ignored; flush and an error report in the same cycle still report err_valid.

Reset
REQ-019 resetn low asynchronously forces IDLE, mem_req=0, mem_wen=0, resp_valid=0, err_valid=0, resp_rdata=0, err_badvaddr=0; req_ready=1 after release.
REQ-020 Reset mid-access abandons it with no response; a late mem_rvalid in IDLE is ignored.

Verification
REQ-021 DATA_W=32, LB signed at addr 0x103, mem_rdata 0x80FF_1234 -> resp_rdata 0xFFFF_FF80.
REQ-022 SH at addr 0x202, wdata 0x0000_BEEF -> mem_wen 4'b1100, mem_wdata 0xBEEF_BEEF, mem_addr 0x200.
REQ-023 LW at addr 0x101 -> err_valid pulse, err_store=0, err_badvaddr 0x101, mem_req never asserted.
REQ-024 DATA_W=64, LHU at 0x1006, mem_rdata 0xABCD_0000_0000_0000 -> resp_rdata 0x0000_0000_0000_ABCD.
REQ-025 Load with flush in WAIT, mem_rvalid 3 cycles later -> no resp_valid, then IDLE; the next request is accepted.
REQ-026 Zero-wait load with resp_ready held low 4 cycles -> resp_valid stays high with stable resp_rdata for 5 cycles.
